motor_pwm_driver: RTL and testbench

- Consumes the 11-bit PID correction word (0..1000, 500 = centred, 0 = PID fault/out-of-range) and drives the left and right motor PWM outputs.
- Converts the correction into differential duty cycles around a base speed, slew-limits the duties, and generates the PWM waveforms.
- Stops the motors when the line is lost; sits between the PID block and the motor H-bridge pins.

---
 rtl/motor_pwm_driver.sv | 236 +++++++++++++++++++++++
 tb/tb_motor_pwm_driver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/motor_pwm_driver.sv
// Differential motor PWM driver: turns the PID correction word into slew-limited
// left/right duties around a base speed and generates the two PWM waveforms.
module motor_pwm_driver #(
    parameter int CLK_DIV      = 100,
    parameter int PWM_PERIOD   = 1000,
    parameter int CENTER       = 500,
    parameter int MAX_DUTY     = 1000,
    parameter int RAMP_STEP    = 20,
    parameter int LOST_PERIODS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [10:0] pid_output,
    input  logic [9:0]  base_speed,
    output logic        pwm_left,
    output logic        pwm_right,
    output logic [9:0]  duty_left,
    output logic [9:0]  duty_right,
    output logic        line_lost,
    output logic        period_start
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int LW = $clog2(LOST_PERIODS + 1);
    localparam int XW = (CW > 10) ? CW : 10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LOST = 2'd2
    } state_t;

    // Clamp a signed target into the legal duty range.
    function automatic logic [9:0] sat_duty(input logic signed [12:0] v);
        logic [9:0] r;
        if (v < 13'sd0) begin
            r = 10'd0;
        end else if (v > $signed(13'(MAX_DUTY))) begin
            r = 10'(MAX_DUTY);
        end else begin
            r = v[9:0];
        end
        return r;
    endfunction

    // Move a duty toward its target by at most RAMP_STEP, never overshooting.
    function automatic logic [9:0] ramp(input logic [9:0] duty, input logic [9:0] tgt);
        logic [9:0] r;
        if (tgt > duty) begin
            if ((tgt - duty) > 10'(RAMP_STEP)) begin
                r = duty + 10'(RAMP_STEP);
            end else begin
                r = tgt;
            end
        end else begin
            if ((duty - tgt) > 10'(RAMP_STEP)) begin
                r = duty - 10'(RAMP_STEP);
            end else begin
                r = tgt;
            end
        end
        return r;
    endfunction

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]   lost_q, lost_d;
    logic [9:0]      tgt_l_q, tgt_l_d;
    logic [9:0]      tgt_r_q, tgt_r_d;
    logic [9:0]      duty_l_q, duty_l_d;
    logic [9:0]      duty_r_q, duty_r_d;
    logic            pwm_l_q, pwm_l_d;
    logic            pwm_r_q, pwm_r_d;
    logic            line_lost_q, line_lost_d;
    logic            period_start_q, period_start_d;

    logic                tick_s;
    logic                boundary_s;
    logic                valid_s;
    logic signed [12:0]  corr_s;
    logic [9:0]          new_tgt_l_s;
    logic [9:0]          new_tgt_r_s;

    // Sample-derived targets, meaningful only when consumed at a boundary.
    always_comb begin
        valid_s     = (pid_output >= 11'd1) && (pid_output <= 11'd1000);
        corr_s      = $signed({2'b00, pid_output}) - $signed(13'(CENTER));
        new_tgt_l_s = sat_duty($signed({3'b000, base_speed}) + corr_s);
        new_tgt_r_s = sat_duty($signed({3'b000, base_speed}) - corr_s);
        tick_s      = (state_q != S_IDLE) && (presc_q == PW'(CLK_DIV - 1));
        boundary_s  = tick_s && (cnt_q == CW'(PWM_PERIOD - 1));
    end

    // Next-state, timebase, ramp and registered-output logic.
    always_comb begin
        state_d        = state_q;
        presc_d        = presc_q;
        cnt_d          = cnt_q;
        lost_d         = lost_q;
        tgt_l_d        = tgt_l_q;
        tgt_r_d        = tgt_r_q;
        duty_l_d       = duty_l_q;
        duty_r_d       = duty_r_q;
        period_start_d = 1'b0;

        if (!enable) begin
            // Disable wins over everything, including a coincident boundary.
            state_d  = S_IDLE;
            presc_d  = '0;
            cnt_d    = '0;
            lost_d   = '0;
            tgt_l_d  = 10'd0;
            tgt_r_d  = 10'd0;
            duty_l_d = 10'd0;
            duty_r_d = 10'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d  = S_RUN;
                    presc_d  = '0;
                    cnt_d    = '0;
                    lost_d   = '0;
                    tgt_l_d  = 10'd0;
                    tgt_r_d  = 10'd0;
                    duty_l_d = 10'd0;
                    duty_r_d = 10'd0;
                end
                S_RUN, S_LOST: begin
                    if (tick_s) begin
                        presc_d = '0;
                        if (boundary_s) begin
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end

                    if (boundary_s) begin
                        period_start_d = 1'b1;
                        if (valid_s) begin
                            state_d = S_RUN;
                            lost_d  = '0;
                            tgt_l_d = new_tgt_l_s;
                            tgt_r_d = new_tgt_r_s;
                            if (state_q == S_LOST) begin
                                duty_l_d = ramp(10'd0, new_tgt_l_s);
                                duty_r_d = ramp(10'd0, new_tgt_r_s);
                            end else begin
                                duty_l_d = ramp(duty_l_q, new_tgt_l_s);
                                duty_r_d = ramp(duty_r_q, new_tgt_r_s);
                            end
                        end else if (state_q == S_RUN) begin
                            if (lost_q >= LW'(LOST_PERIODS - 1)) begin
                                state_d  = S_LOST;
                                lost_d   = LW'(LOST_PERIODS);
                                duty_l_d = 10'd0;
                                duty_r_d = 10'd0;
                            end else begin
                                lost_d   = lost_q + LW'(1);
                                duty_l_d = ramp(duty_l_q, tgt_l_q);
                                duty_r_d = ramp(duty_r_q, tgt_r_q);
                            end
                        end else begin
                            duty_l_d = 10'd0;
                            duty_r_d = 10'd0;
                        end
                    end else begin
                        period_start_d = 1'b0;
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    presc_d  = '0;
                    cnt_d    = '0;
                    lost_d   = '0;
                    duty_l_d = 10'd0;
                    duty_r_d = 10'd0;
                end
            endcase
        end

        // PWM compares the current counter with the current duty; one clk of lag.
        if (state_d != S_IDLE) begin
            pwm_l_d = (XW'(cnt_q) < XW'(duty_l_q));
            pwm_r_d = (XW'(cnt_q) < XW'(duty_r_q));
        end else begin
            pwm_l_d = 1'b0;
            pwm_r_d = 1'b0;
        end
        line_lost_d = (state_d == S_LOST);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            presc_q        <= '0;
            cnt_q          <= '0;
            lost_q         <= '0;
            tgt_l_q        <= 10'd0;
            tgt_r_q        <= 10'd0;
            duty_l_q       <= 10'd0;
            duty_r_q       <= 10'd0;
            pwm_l_q        <= 1'b0;
            pwm_r_q        <= 1'b0;
            line_lost_q    <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            presc_q        <= presc_d;
            cnt_q          <= cnt_d;
            lost_q         <= lost_d;
            tgt_l_q        <= tgt_l_d;
            tgt_r_q        <= tgt_r_d;
            duty_l_q       <= duty_l_d;
            duty_r_q       <= duty_r_d;
            pwm_l_q        <= pwm_l_d;
            pwm_r_q        <= pwm_r_d;
            line_lost_q    <= line_lost_d;
            period_start_q <= period_start_d;
        end
    end

    assign pwm_left     = pwm_l_q;
    assign pwm_right    = pwm_r_q;
    assign duty_left    = duty_l_q;
    assign duty_right   = duty_r_q;
    assign line_lost    = line_lost_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Self-checking bench for motor_pwm_driver: vector table, hand sequences and
// randomized samples checked against a period-level behavioural model.
module tb_motor_pwm_driver;

    localparam int CLK_DIV      = 2;
    localparam int PWM_PERIOD   = 500;
    localparam int CENTER       = 500;
    localparam int MAX_DUTY     = 500;
    localparam int RAMP_STEP    = 50;
    localparam int LOST_PERIODS = 3;
    localparam int PCLKS        = CLK_DIV * PWM_PERIOD;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [10:0] pid;
    logic [9:0]  base;
    logic        pwm_left, pwm_right, line_lost, period_start;
    logic [9:0]  duty_left, duty_right;

    motor_pwm_driver #(
        .CLK_DIV(CLK_DIV), .PWM_PERIOD(PWM_PERIOD), .CENTER(CENTER),
        .MAX_DUTY(MAX_DUTY), .RAMP_STEP(RAMP_STEP), .LOST_PERIODS(LOST_PERIODS)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .pid_output(pid), .base_speed(base),
        .pwm_left(pwm_left), .pwm_right(pwm_right), .duty_left(duty_left),
        .duty_right(duty_right), .line_lost(line_lost), .period_start(period_start)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Period-level model: 0 = idle, 1 = run, 2 = lost
    int m_mode, m_tl, m_tr, m_lc, m_dl, m_dr;

    function automatic int clampd(input int v);
        if (v < 0) return 0;
        if (v > MAX_DUTY) return MAX_DUTY;
        return v;
    endfunction

    function automatic int stepd(input int d, input int t);
        int diff = (t > d) ? t - d : d - t;
        int s = (diff < RAMP_STEP) ? diff : RAMP_STEP;
        return (t > d) ? d + s : d - s;
    endfunction

    task automatic model_enable();
        m_mode = 1; m_tl = 0; m_tr = 0; m_lc = 0; m_dl = 0; m_dr = 0;
    endtask

    task automatic model_boundary(input int p, input int b);
        bit valid = (p >= 1) && (p <= 1000);
        if (valid) begin
            m_tl = clampd(b + (p - CENTER));
            m_tr = clampd(b - (p - CENTER));
            m_lc = 0;
            if (m_mode == 2) begin
                m_dl = 0; m_dr = 0;
            end
            m_mode = 1;
            m_dl = stepd(m_dl, m_tl);
            m_dr = stepd(m_dr, m_tr);
        end else if (m_mode == 1) begin
            m_lc++;
            if (m_lc >= LOST_PERIODS) begin
                m_mode = 2; m_dl = 0; m_dr = 0;
            end else begin
                m_dl = stepd(m_dl, m_tl);
                m_dr = stepd(m_dr, m_tr);
            end
        end
    endtask

    // Waits for the next period_start; returns clks waited and pwm high clks seen.
    task automatic wait_ps(output int waited, output int hi_l, output int hi_r);
        waited = 0; hi_l = 0; hi_r = 0;
        do begin
            @(negedge clk);
            waited++;
            hi_l += int'(pwm_left);
            hi_r += int'(pwm_right);
        end while (!period_start && waited < PCLKS + 100);
        if (!period_start) check("period_start_timeout", int'(period_start), 1);
    endtask

    task automatic count_idle(input string name);
        int ps = 0;
        repeat (PCLKS + 200) begin
            @(negedge clk);
            ps += int'(period_start);
        end
        check(name, ps, 0);
    endtask

    typedef struct {
        int pid;
        int base;
        int el;
        int er;
        int elost;
    } vec_t;

    vec_t vecs[18];

    initial begin
        int w, hl, hr, p, b;

        vecs[0]  = '{600,  200, 250, 150, 0};
        vecs[1]  = '{600,  200, 300, 100, 0};
        vecs[2]  = '{600,  200, 300, 100, 0};
        vecs[3]  = '{1000, 200, 350,  50, 0};
        vecs[4]  = '{1000, 200, 400,   0, 0};
        vecs[5]  = '{1000, 200, 450,   0, 0};
        vecs[6]  = '{1000, 200, 500,   0, 0};
        vecs[7]  = '{1000, 200, 500,   0, 0};
        vecs[8]  = '{0,    200, 500,   0, 0};
        vecs[9]  = '{0,    200, 500,   0, 0};
        vecs[10] = '{500,  200, 450,  50, 0};
        vecs[11] = '{0,    200, 400, 100, 0};
        vecs[12] = '{1001, 200, 350, 150, 0};
        vecs[13] = '{2047, 200,   0,   0, 1};
        vecs[14] = '{0,    200,   0,   0, 1};
        vecs[15] = '{1000, 200,  50,   0, 0};
        vecs[16] = '{1,    300,   0,  50, 0};
        vecs[17] = '{500,  100,  50, 100, 0};

        rst = 1'b1; enable = 1'b0; pid = 11'd500; base = 10'd0;
        m_mode = 0; m_tl = 0; m_tr = 0; m_lc = 0; m_dl = 0; m_dr = 0;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({pwm_left, pwm_right, duty_left, duty_right,
                                     line_lost, period_start}), 0);
        rst = 1'b0;
        count_idle("idle_no_period_start");
        check("idle_duty_left", int'(duty_left), 0);

        // Enable is registered on the first edge, then one full period elapses.
        base = 10'd200; pid = 11'd500; enable = 1'b1;
        model_enable();
        wait_ps(w, hl, hr);
        check("first_period_latency", w, PCLKS + 1);
        model_boundary(int'(pid), int'(base));
        check("ramp1_left", int'(duty_left), RAMP_STEP);
        check("ramp1_right", int'(duty_right), RAMP_STEP);
        for (int k = 2; k <= 6; k++) begin
            wait_ps(w, hl, hr);
            model_boundary(int'(pid), int'(base));
            check("ramp_left", int'(duty_left), (k * RAMP_STEP < 200) ? k * RAMP_STEP : 200);
            check("ramp_right", int'(duty_right), (k * RAMP_STEP < 200) ? k * RAMP_STEP : 200);
        end
        check("pwm_left_high_clks", hl, 200 * CLK_DIV);
        check("pwm_right_high_clks", hr, 200 * CLK_DIV);

        for (int i = 0; i < 18; i++) begin
            pid = 11'(vecs[i].pid); base = 10'(vecs[i].base);
            wait_ps(w, hl, hr);
            model_boundary(vecs[i].pid, vecs[i].base);
            check("vec_duty_left", int'(duty_left), vecs[i].el);
            check("vec_duty_right", int'(duty_right), vecs[i].er);
            check("vec_line_lost", int'(line_lost), vecs[i].elost);
        end

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(3) == 0) p = ($urandom_range(1) == 1) ? 0 : int'($urandom_range(2047, 1001));
            else p = int'($urandom_range(1000, 1));
            b = int'($urandom_range(1023, 0));
            pid = 11'(p); base = 10'(b);
            wait_ps(w, hl, hr);
            model_boundary(p, b);
            check("rand_duty_left", int'(duty_left), m_dl);
            check("rand_duty_right", int'(duty_right), m_dr);
            check("rand_line_lost", int'(line_lost), (m_mode == 2) ? 1 : 0);
        end

        // Drop enable mid-period with nonzero duties.
        pid = 11'd500; base = 10'd400;
        repeat (2) begin
            wait_ps(w, hl, hr);
            model_boundary(int'(pid), int'(base));
        end
        check("pre_drop_duty_left", int'(duty_left), m_dl);
        repeat (300) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("drop_outputs", int'({pwm_left, pwm_right, duty_left, duty_right,
                                    line_lost, period_start}), 0);
        count_idle("disabled_no_period_start");

        enable = 1'b1;
        model_enable();
        wait_ps(w, hl, hr);
        check("reenable_latency", w, PCLKS + 1);
        model_boundary(int'(pid), int'(base));
        check("reenable_duty_left", int'(duty_left), RAMP_STEP);
        check("reenable_duty_right", int'(duty_right), RAMP_STEP);

        // Asynchronous reset while pwm_left is high.
        repeat (20) @(negedge clk);
        check("pre_reset_pwm_left", int'(pwm_left), 1);
        rst = 1'b1; enable = 1'b0;
        #1;
        check("async_reset_outputs", int'({pwm_left, pwm_right, duty_left, duty_right,
                                           line_lost, period_start}), 0);
        @(negedge clk);
        rst = 1'b0;
        count_idle("post_reset_idle");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
